// File: rtl/keccak_absorb_loader.sv
// Packs a message word stream into Keccak rate blocks with SHAKE/SHA3 padding.
// Define KECCAK_LOADER_SHA3_MODES_EN to add the SHA3-224/256/384/512 modes.
module keccak_absorb_loader #(
   parameter int W        = 64,
   parameter int RATE_MAX = 1344
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [2:0]          cfg_mode,
   input  logic [31:0]         cfg_in_bytes,
   input  logic [31:0]         cfg_out_bits,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [W-1:0]        in_data,
   output logic                blk_valid,
   input  logic                blk_ready,
   output logic [RATE_MAX-1:0] blk_data,
   output logic                blk_last,
   output logic [2:0]          mode_out,
   output logic [31:0]         out_bits
);
   localparam int          BPW       = W / 8;
   localparam int          MAX_WORDS = RATE_MAX / W;
   localparam logic [31:0] BPW32     = 32'(BPW);

   typedef enum logic [1:0] {IDLE, LOAD, PAD, EMIT} state_t;
   state_t state_q, state_d;

   logic [RATE_MAX-1:0] buf_q;
   logic [31:0]         rem_q;
   logic [7:0]          wcnt_q;
   logic                dom_q;
   logic                last_q;
   logic [2:0]          mode_q;
   logic [31:0]         out_bits_q;

   logic [2:0]  cfg_mode_eff;
   logic [7:0]  rate_bytes, words_per_blk, domain;
   logic [31:0] take, rem_next;
   logic        dom_next, last_word, word_we;
   logic [W-1:0] gen_word;

`ifdef KECCAK_LOADER_SHA3_MODES_EN
   always_comb cfg_mode_eff = (cfg_mode <= 3'd5) ? cfg_mode : 3'd0;
`else
   always_comb cfg_mode_eff = (cfg_mode == 3'd1) ? 3'd1 : 3'd0;
`endif

   always_comb begin
      case (mode_q)
         3'd1:    rate_bytes = 8'd136;
`ifdef KECCAK_LOADER_SHA3_MODES_EN
         3'd2:    rate_bytes = 8'd144;
         3'd3:    rate_bytes = 8'd136;
         3'd4:    rate_bytes = 8'd104;
         3'd5:    rate_bytes = 8'd72;
`endif
         default: rate_bytes = 8'd168;
      endcase
      words_per_blk = rate_bytes / 8'(BPW);
      domain        = (mode_q <= 3'd1) ? 8'h1F : 8'h06;
   end

   // One word per write: message bytes, then the domain byte once, then zeros;
   // the closing 0x80 lands in the last rate word of the block holding the domain byte.
   always_comb begin
      take      = (rem_q < BPW32) ? rem_q : BPW32;
      rem_next  = rem_q - take;
      dom_next  = dom_q | (rem_q < BPW32);
      last_word = (wcnt_q == words_per_blk - 8'd1);
      gen_word  = '0;
      for (int j = 0; j < BPW; j++) begin
         if (32'(j) < rem_q)
            gen_word[8*j +: 8] = in_data[W-1-8*j -: 8];
         else if (32'(j) == rem_q && !dom_q)
            gen_word[8*j +: 8] = domain;
      end
      if (last_word && dom_next)
         gen_word[W-1 -: 8] = gen_word[W-1 -: 8] | 8'h80;
   end

   always_comb word_we = ((state_q == LOAD) && in_valid) || (state_q == PAD);

   always_comb begin
      state_d   = state_q;
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
      blk_valid = 1'b0;
      case (state_q)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid)
               state_d = (cfg_in_bytes != 32'd0) ? LOAD : PAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (last_word)
                  state_d = EMIT;
               else if (rem_next == 32'd0)
                  state_d = PAD;
            end
         end
         PAD: begin
            if (last_word)
               state_d = EMIT;
         end
         EMIT: begin
            blk_valid = 1'b1;
            if (blk_ready)
               state_d = last_q ? IDLE : ((rem_q != 32'd0) ? LOAD : PAD);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         rem_q      <= '0;
         wcnt_q     <= '0;
         dom_q      <= 1'b0;
         last_q     <= 1'b0;
         mode_q     <= '0;
         out_bits_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (cfg_valid) begin
                  mode_q     <= cfg_mode_eff;
                  out_bits_q <= cfg_out_bits;
                  rem_q      <= cfg_in_bytes;
                  wcnt_q     <= '0;
                  dom_q      <= 1'b0;
                  last_q     <= 1'b0;
               end
            end
            LOAD, PAD: begin
               if (word_we) begin
                  for (int w = 0; w < MAX_WORDS; w++)
                     if (wcnt_q == 8'(w))
                        buf_q[w*W +: W] <= gen_word;
                  rem_q  <= rem_next;
                  dom_q  <= dom_next;
                  wcnt_q <= wcnt_q + 8'd1;
                  if (last_word)
                     last_q <= dom_next;
               end
            end
            EMIT: begin
               if (blk_ready) begin
                  buf_q  <= '0;
                  wcnt_q <= '0;
                  last_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign blk_data = buf_q;
   assign blk_last = last_q;
   assign mode_out = mode_q;
   assign out_bits = out_bits_q;

endmodule

// File: tb/tb_keccak_absorb_loader.sv
// Scoreboard bench for keccak_absorb_loader (W=64): a padding model queues expected
// blocks as each message is configured; blocks are popped and compared on output.
module tb_keccak_absorb_loader;
   localparam int W        = 64;
   localparam int RATE_MAX = 1344;
   localparam int BPW      = W / 8;

   typedef struct {
      logic [RATE_MAX-1:0] data;
      logic                last;
   } exp_blk_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                cfg_valid, cfg_ready;
   logic [2:0]          cfg_mode;
   logic [31:0]         cfg_in_bytes, cfg_out_bits;
   logic                in_valid, in_ready;
   logic [W-1:0]        in_data;
   logic                blk_valid, blk_ready, blk_last;
   logic [RATE_MAX-1:0] blk_data;
   logic [2:0]          mode_out;
   logic [31:0]         out_bits;

   exp_blk_t   sb[$];
   logic [7:0] msg [0:1023];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   keccak_absorb_loader #(.W(W), .RATE_MAX(RATE_MAX)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode),
      .cfg_in_bytes(cfg_in_bytes), .cfg_out_bits(cfg_out_bits),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
      .mode_out(mode_out), .out_bits(out_bits)
   );

   function automatic int effMode(input int m);
`ifdef KECCAK_LOADER_SHA3_MODES_EN
      return (m <= 5) ? m : 0;
`else
      return (m == 1) ? 1 : 0;
`endif
   endfunction

   function automatic int rateOf(input int m);
      case (m)
         1:       return 136;
         2:       return 144;
         3:       return 136;
         4:       return 104;
         5:       return 72;
         default: return 168;
      endcase
   endfunction

   // Byte 0 of the word sits in the top byte; bytes past the message are 0xFF junk.
   function automatic logic [W-1:0] wordAt(input int widx, input int nbytes);
      logic [W-1:0] w;
      int           idx;
      w = '0;
      for (int j = 0; j < BPW; j++) begin
         idx = widx * BPW + j;
         w[W-1-8*j -: 8] = (idx < nbytes) ? msg[idx] : 8'hFF;
      end
      return w;
   endfunction

   task automatic checkValue(input string tag, input logic [RATE_MAX-1:0] obs,
                             input logic [RATE_MAX-1:0] expv);
      int k;
      checks++;
      k = 0;
      while (k < RATE_MAX/8 - 1 && obs[8*k +: 8] === expv[8*k +: 8]) k++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s at byte %0d: observed %02h expected %02h", tag, k,
                obs[8*k +: 8], expv[8*k +: 8]);
      end
   endtask

   // Reference pad10*1: domain byte right after the message, 0x80 ORed into the last byte.
   task automatic buildExpected(input int mode, input int nbytes);
      int         rate, total, nblk, idx;
      logic [7:0] dom, v;
      exp_blk_t   e;
      rate  = rateOf(mode);
      dom   = (mode <= 1) ? 8'h1F : 8'h06;
      total = (nbytes / rate + 1) * rate;
      nblk  = total / rate;
      for (int b = 0; b < nblk; b++) begin
         e.data = '0;
         for (int k = 0; k < rate; k++) begin
            idx = b * rate + k;
            if (idx < nbytes)       v = msg[idx];
            else if (idx == nbytes) v = dom;
            else                    v = 8'h00;
            if (idx == total - 1)   v = v | 8'h80;
            e.data[8*k +: 8] = v;
         end
         e.last = (b == nblk - 1);
         sb.push_back(e);
      end
   endtask

   task automatic checkOutput();
      exp_blk_t e;
      if (sb.size() == 0) begin
         checkValue("unexpected_blk", RATE_MAX'(blk_valid), '0);
         return;
      end
      e = sb.pop_front();
      checkValue("blk_data", blk_data, e.data);
      checkValue("blk_last", RATE_MAX'(blk_last), RATE_MAX'(e.last));
   endtask

   task automatic applyStimulus(input int mode, input int nbytes, input int stall_cycles);
      int          widx, nwords, cycles, stall;
      logic [31:0] ob;
      bit          hs;
      widx   = 0;
      cycles = 0;
      stall  = stall_cycles;
      nwords = (nbytes + BPW - 1) / BPW;
      ob     = $urandom;
      buildExpected(effMode(mode), nbytes);
      @(negedge clk);
      checkValue("cfg_ready_idle", RATE_MAX'(cfg_ready), RATE_MAX'(1));
      cfg_valid    = 1'b1;
      cfg_mode     = 3'(mode);
      cfg_in_bytes = 32'(nbytes);
      cfg_out_bits = ob;
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      checkValue("mode_out", RATE_MAX'(mode_out), RATE_MAX'(effMode(mode)));
      checkValue("out_bits", RATE_MAX'(out_bits), RATE_MAX'(ob));
      while (sb.size() > 0 && cycles < 5000) begin
         if (blk_valid && stall > 0) begin
            checkValue("stall_blk_data", blk_data, sb[0].data);
            checkValue("stall_in_ready", RATE_MAX'(in_ready), '0);
            blk_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = {$urandom, $urandom};
            stall--;
            hs = 1'b0;
         end else begin
            if (blk_valid) checkOutput();
            blk_ready = 1'b1;
            in_valid  = (widx < nwords);
            in_data   = wordAt(widx, nbytes);
            hs        = in_ready && in_valid;
         end
         @(posedge clk);
         @(negedge clk);
         if (hs) widx++;
         cycles++;
      end
      in_valid  = 1'b0;
      blk_ready = 1'b0;
      checkValue("blocks_outstanding", RATE_MAX'(sb.size()), '0);
      checkValue("in_handshakes", RATE_MAX'(widx), RATE_MAX'(nwords));
      checkValue("back_to_idle", RATE_MAX'(cfg_ready), RATE_MAX'(1));
      sb.delete();
   endtask

   initial begin
      int fed, cycles;
      bit hs, seen;
      rst          = 1'b1;
      cfg_valid    = 1'b0;
      cfg_mode     = '0;
      cfg_in_bytes = '0;
      cfg_out_bits = '0;
      in_valid     = 1'b0;
      in_data      = '0;
      blk_ready    = 1'b0;
      for (int i = 0; i < 1024; i++) msg[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checkValue("rst_cfg_ready", RATE_MAX'(cfg_ready), RATE_MAX'(1));
      checkValue("rst_in_ready", RATE_MAX'(in_ready), '0);
      checkValue("rst_blk_valid", RATE_MAX'(blk_valid), '0);
      checkValue("rst_blk_last", RATE_MAX'(blk_last), '0);
      checkValue("rst_blk_data", blk_data, '0);
      checkValue("rst_mode_out", RATE_MAX'(mode_out), '0);
      checkValue("rst_out_bits", RATE_MAX'(out_bits), '0);

      $display("[TB] empty SHAKE128 message");
      applyStimulus(0, 0, 0);
      $display("[TB] SHAKE256 message filling exactly one block");
      applyStimulus(1, 136, 0);
      $display("[TB] SHAKE256 domain byte on the last rate byte");
      applyStimulus(1, 135, 0);
      $display("[TB] mode 3, 135 bytes");
      applyStimulus(3, 135, 0);
      $display("[TB] short final word with junk bytes");
      msg[0] = 8'hAA;
      msg[1] = 8'hBB;
      msg[2] = 8'hCC;
      applyStimulus(0, 3, 0);
      $display("[TB] two-block SHAKE128 message");
      applyStimulus(0, 200, 0);
      $display("[TB] blk_ready held low in EMIT");
      applyStimulus(0, 10, 10);

      $display("[TB] reset in the middle of a message");
      @(negedge clk);
      cfg_valid    = 1'b1;
      cfg_mode     = 3'd0;
      cfg_in_bytes = 32'd200;
      cfg_out_bits = 32'd256;
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      fed    = 0;
      cycles = 0;
      while (fed < 5 && cycles < 100) begin
         in_valid = 1'b1;
         in_data  = wordAt(fed, 200);
         hs       = in_ready;
         @(posedge clk);
         @(negedge clk);
         if (hs) fed++;
         cycles++;
      end
      in_valid = 1'b0;
      checkValue("rst_words_fed", RATE_MAX'(fed), RATE_MAX'(5));
      rst = 1'b1;
      #1;
      checkValue("midrst_blk_valid", RATE_MAX'(blk_valid), '0);
      checkValue("midrst_blk_data", blk_data, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkValue("midrst_cfg_ready", RATE_MAX'(cfg_ready), RATE_MAX'(1));
      checkValue("midrst_out_bits", RATE_MAX'(out_bits), '0);
      seen = 1'b0;
      blk_ready = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (blk_valid) seen = 1'b1;
      end
      blk_ready = 1'b0;
      checkValue("no_blk_after_rst", RATE_MAX'(seen), '0);
      applyStimulus(0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
